// File: rtl/clock_divider_pkg.sv
// Shared constants and sizing helpers for the clock_divider_bank block and its
// per-channel divider.
package clock_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_STOPPED       = 0;

    typedef logic [DIV_WIDTH_DEFAULT-1:0] divisor_t;

    // A single-channel bank still needs a one-bit channel index port.
    function automatic int chan_idx_bits(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One runtime-programmable divider channel. It holds an active/shadow divisor
// pair so that a reprogrammed divisor only takes effect at a period boundary.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int Width          = DIV_WIDTH_DEFAULT,
    parameter int DefaultDivisor = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [Width-1:0] DefaultDiv = Width'(DefaultDivisor);

    logic [Width-1:0] cnt;
    logic [Width-1:0] active_div;
    logic [Width-1:0] shadow_div;

    logic stopped;
    logic advance;
    logic at_boundary;

    assign stopped     = (active_div == Width'(DIV_STOPPED));
    assign advance     = enable && !stopped;
    assign at_boundary = (cnt == active_div - Width'(1));

    // NOTE: every piece of state is a register written with <= so all
    // channel fields update together on the edge, whatever the branch order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            active_div <= DefaultDiv;
            shadow_div <= DefaultDiv;
            pending    <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else if (restart) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (wr_en) begin
                active_div <= wr_div;
                shadow_div <= wr_div;
            end else if (pending) begin
                active_div <= shadow_div;
            end
        end else begin
            if (advance) begin
                tick    <= (cnt == '0);
                clk_out <= (cnt < (active_div >> 1));
                cnt     <= at_boundary ? '0 : cnt + Width'(1);
            end else begin
                tick <= 1'b0;
                if (stopped) begin
                    clk_out <= 1'b0;
                    cnt     <= '0;
                end
            end

            // A write landing on the boundary itself is the newest value, so it
            // wins over an older shadow.
            if (advance && at_boundary) begin
                pending <= 1'b0;
                if (wr_en) begin
                    active_div <= wr_div;
                    shadow_div <= wr_div;
                end else if (pending) begin
                    active_div <= shadow_div;
                end
            end else if (wr_en) begin
                shadow_div <= wr_div;
                if (advance) begin
                    pending <= 1'b1;
                end else begin
                    active_div <= wr_div;
                    cnt        <= '0;
                    pending    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent runtime-programmable clock dividers that share one write
// port. The write port is decoded into one strobe per channel.
module clock_divider_bank
    import clock_divider_pkg::*;
#(
    parameter int  NumChannels    = 4,
    parameter int  Width          = DIV_WIDTH_DEFAULT,
    parameter int  DefaultDivisor = 4,
    localparam int ChanBits       = chan_idx_bits(NumChannels)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NumChannels-1:0] enable,
    input  logic [NumChannels-1:0] restart,
    input  logic                   wr_en,
    input  logic [ChanBits-1:0]    wr_chan,
    input  logic [Width-1:0]       wr_div,
    output logic [NumChannels-1:0] clk_out,
    output logic [NumChannels-1:0] tick,
    output logic [NumChannels-1:0] pending
);

    logic [NumChannels-1:0] chan_wr;

    for (genvar i = 0; i < NumChannels; i++) begin : g_chan
        // Indices at or above NumChannels match no channel and are dropped.
        assign chan_wr[i] = wr_en && (wr_chan == ChanBits'(i));

        clock_divider_channel #(
            .Width          (Width),
            .DefaultDivisor (DefaultDivisor)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable[i]),
            .restart (restart[i]),
            .wr_en   (chan_wr[i]),
            .wr_div  (wr_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: each stimulus cycle queues the
// hand-derived outputs expected after its edge; a monitor pops and checks them.
module tb_clock_divider_bank;

    localparam int N = 5;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] enable;
    logic [N-1:0] restart;
    logic         wr_en;
    logic [2:0]   wr_chan;
    logic [W-1:0] wr_div;
    logic [N-1:0] clk_out;
    logic [N-1:0] tick;
    logic [N-1:0] pending;

    clock_divider_bank #(
        .NumChannels    (N),
        .Width          (W),
        .DefaultDivisor (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .restart (restart),
        .wr_en   (wr_en),
        .wr_chan (wr_chan),
        .wr_div  (wr_div),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] care_o;
        logic [N-1:0] care_p;
        logic [N-1:0] exp_clk;
        logic [N-1:0] exp_tick;
        logic [N-1:0] exp_pend;
        int           step;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_mis   = 0;
    int   step_no = 0;

    task automatic check(input string name, input int step,
                         input logic [N-1:0] got, input logic [N-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s step %0d: got %b want %b", name, step, got, want);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.care_o != '0) begin
                check("clk_out", mon_e.step, clk_out & mon_e.care_o, mon_e.exp_clk & mon_e.care_o);
                check("tick", mon_e.step, tick & mon_e.care_o, mon_e.exp_tick & mon_e.care_o);
            end
            if (mon_e.care_p != '0)
                check("pending", mon_e.step, pending & mon_e.care_p, mon_e.exp_pend & mon_e.care_p);
        end
    end

    // One clock cycle with the current inputs; write/restart strobes are one-shot.
    task automatic cyc(input logic [N-1:0] co, input logic [N-1:0] cp, input logic [N-1:0] ec,
                       input logic [N-1:0] et, input logic [N-1:0] ep);
        exp_t e;
        e.care_o   = co;
        e.care_p   = cp;
        e.exp_clk  = ec;
        e.exp_tick = et;
        e.exp_pend = ep;
        e.step     = step_no;
        step_no++;
        sb.push_back(e);
        @(negedge clk);
        #1;
        wr_en   = 1'b0;
        restart = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0, '0, '0, '0);
    endtask

    function automatic logic [N-1:0] sel(input int ch, input string s, input int i);
        logic [N-1:0] v = '0;
        if (s.getc(i) == "1") v[ch] = 1'b1;
        return v;
    endfunction

    task automatic run_pattern(input int ch, input string pc, input string pt, input string pp);
        logic [N-1:0] m = '0;
        m[ch] = 1'b1;
        for (int i = 0; i < pc.len(); i++)
            cyc(m, m, sel(ch, pc, i), sel(ch, pt, i), sel(ch, pp, i));
    endtask

    task automatic run_pair(input int ca, input string ac, input string at,
                            input int cb, input string bc, input string bt,
                            input logic [N-1:0] pend_care);
        logic [N-1:0] m = '0;
        m[ca] = 1'b1;
        m[cb] = 1'b1;
        for (int i = 0; i < ac.len(); i++)
            cyc(m, pend_care, sel(ca, ac, i) | sel(cb, bc, i), sel(ca, at, i) | sel(cb, bt, i), '0);
    endtask

    task automatic write(input int ch, input int d);
        wr_en   = 1'b1;
        wr_chan = 3'(ch);
        wr_div  = W'(d);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = '0;
        restart = '0;
        wr_en   = 1'b0;
        wr_chan = '0;
        wr_div  = '0;

        // Reset state on every channel.
        cyc('1, '1, '0, '0, '0);
        cyc('1, '1, '0, '0, '0);
        rst = 1'b0;

        // Default divisor 4 on ch0.
        enable[0] = 1'b1;
        run_pattern(0, "11001100", "10001000", "00000000");

        // Mid-period write of 5 to running ch1: old period finishes, then 11000.
        enable[1] = 1'b1;
        run_pattern(1, "1", "1", "0");
        write(1, 5);
        run_pattern(1, "1001100011000", "0001000010000", "1100000000000");

        // Write of 6 to disabled ch2 applies at once; then three-high/three-low.
        write(2, 6);
        run_pattern(2, "0", "0", "0");
        enable[2] = 1'b1;
        run_pattern(2, "111000111000", "100000100000", "000000000000");

        // Pause ch0 for 7 cycles mid-period; it resumes where it left off.
        restart[0] = 1'b1;
        run_pattern(0, "0", "0", "0");
        run_pattern(0, "11", "10", "00");
        enable[0] = 1'b0;
        run_pattern(0, "1111111", "0000000", "0000000");
        enable[0] = 1'b1;
        run_pattern(0, "0011", "0010", "0000");

        // ch3 on D=3, ch4 on D=4 at unrelated phases, then restarted together.
        write(3, 3);
        idle(1);
        enable[3] = 1'b1;
        idle(2);
        enable[4] = 1'b1;
        idle(3);
        restart = 5'b11000;
        run_pair(3, "0", "0", 4, "0", "0", '0);
        run_pair(3, "100100", "100100", 4, "110011", "100010", '0);

        // Out-of-range channel index: nothing changes anywhere.
        write(N, 9);
        run_pair(3, "100100", "100100", 4, "001100", "001000", '1);

        // D=0 on ch3 waits for the boundary, then the channel is silent.
        write(3, 0);
        run_pattern(3, "100000000", "100000000", "110000000");

        // D=1 on a stopped ch3 applies at once: tick every cycle, clk_out low.
        write(3, 1);
        run_pattern(3, "00000", "01111", "00000");

        // Reset mid-period clears everything and restores D=4.
        rst = 1'b1;
        cyc('1, '1, '0, '0, '0);
        rst = 1'b0;
        run_pattern(3, "1100", "1000", "0000");

        // Restart applies a pending divisor immediately.
        write(4, 2);
        run_pattern(4, "1", "1", "1");
        restart[4] = 1'b1;
        run_pattern(4, "01010", "01010", "00000");

        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
